// File: rtl/resource_unit.sv
// Iterative rotate-and-accumulate unit: one operand in, ITER partial sums of
// rotl(D,k) folded into one DATA_W-bit result, handed downstream with stall/flush.
module resource_unit #(
    parameter int DATA_W = 32,
    parameter int ITER   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_flush,
    output logic              out_stall,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_flush,
    input  logic              in_stall,
    output logic [15:0]       out_count,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: an operand is taken on an edge with in_valid=1 and out_stall=0;
    // a result is taken on an edge with out_valid=1 and in_stall=0; in_flush=1 on
    // an edge overrides both and returns the unit to IDLE.
    localparam int CNT_W = (ITER < 2) ? 1 : $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [15:0]         count_q, count_d;
    logic                flush_q;

    logic [2*DATA_W-1:0] rot_wide;
    logic [DATA_W-1:0]   rot_term;
    logic [DATA_W-1:0]   acc_sum;

    // Upper half of the doubled word shifted left is the left rotation.
    assign rot_wide = {data_q, data_q} << cnt_q;
    assign rot_term = rot_wide[2*DATA_W-1:DATA_W];
    assign acc_sum  = acc_q + rot_term;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        count_d = count_q;
        if (in_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_d = in_data;
                        acc_d  = in_data;
                        cnt_d  = CNT_W'(1);
                        if (ITER == 1) begin
                            state_d = DONE;
                            res_d   = in_data;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d = DONE;
                        res_d   = acc_sum;
                    end
                end
                DONE: begin
                    if (!in_stall) begin
                        state_d = IDLE;
                        count_d = count_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            count_q <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            count_q <= count_d;
            flush_q <= in_flush;
        end
    end

    // res_q only changes on entry to DONE, so out_data never shows partial sums.
    assign out_stall   = (state_q != IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_data    = res_q;
    assign out_flush   = flush_q;
    assign out_count   = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_resource_unit.sv
// Bench for resource_unit: ITER=4 and ITER=1 instances share stimulus and are
// checked every cycle against a timing-level model plus literal expectations.
module tb_resource_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_flush = 1'b0;
    logic        in_stall = 1'b0;
    logic        preload = 1'b0;

    logic        os4, ov4, of4, os1, ov1, of1;
    logic [31:0] od4, od1;
    logic [15:0] oc4, oc1;
    logic [1:0]  st4, st1;

    int vectors = 0;
    int miscompares = 0;

    resource_unit #(.DATA_W(32), .ITER(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_flush(in_flush), .out_stall(os4), .out_data(od4), .out_valid(ov4),
        .out_flush(of4), .in_stall(in_stall), .out_count(oc4), .dbg_state_o(st4)
    );

    resource_unit #(.DATA_W(32), .ITER(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_flush(in_flush), .out_stall(os1), .out_data(od1), .out_valid(ov1),
        .out_flush(of1), .in_stall(in_stall), .out_count(oc1), .dbg_state_o(st1)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          hold_m[2] = '{1'b0, 1'b0};
    int          rdy_m[2]  = '{0, 0};
    logic [31:0] res_m[2]  = '{32'h0, 32'h0};
    logic [31:0] last_m[2] = '{32'h0, 32'h0};
    logic [15:0] cnt_m[2]  = '{16'h0, 16'h0};
    logic        fl_m = 1'b0;
    int          cyc = 0;
    logic [31:0] exp_q[$];

    function automatic int iter_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [31:0] rsum(input logic [31:0] d, input int n);
        logic [31:0] s = 32'h0;
        for (int k = 0; k < n; k++)
            s = s + ((k == 0) ? d : ((d << k) | (d >> (32 - k))));
        return s;
    endfunction

    function automatic bit e_valid(input int i);
        return hold_m[i] && (cyc >= rdy_m[i]);
    endfunction

    always @(posedge clk or negedge reset or posedge preload) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                hold_m[i] = 1'b0;
                last_m[i] = 32'h0;
                cnt_m[i]  = 16'h0;
            end
            fl_m = 1'b0;
            exp_q.delete();
        end else if (preload) begin
            cnt_m[0] = 16'hFFFF;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (in_flush) begin
                    hold_m[i] = 1'b0;
                    if (i == 0) exp_q.delete();
                end else if (hold_m[i]) begin
                    if (cyc >= rdy_m[i] && !in_stall) begin
                        hold_m[i] = 1'b0;
                        cnt_m[i]  = cnt_m[i] + 16'd1;
                    end
                end else if (in_valid) begin
                    hold_m[i] = 1'b1;
                    res_m[i]  = rsum(in_data, iter_of(i));
                    rdy_m[i]  = cyc + iter_of(i);
                    if (i == 0) exp_q.push_back(res_m[i]);
                end
                if (hold_m[i] && (cyc + 1 == rdy_m[i])) last_m[i] = res_m[i];
            end
            fl_m = in_flush;
            cyc  = cyc + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("valid4", 32'(ov4), 32'(e_valid(0)));
        check("stall4", 32'(os4), 32'(hold_m[0]));
        check("data4",  od4, last_m[0]);
        check("flush4", 32'(of4), 32'(fl_m));
        check("count4", 32'(oc4), 32'(cnt_m[0]));
        check("valid1", 32'(ov1), 32'(e_valid(1)));
        check("stall1", 32'(os1), 32'(hold_m[1]));
        check("data1",  od1, last_m[1]);
        check("flush1", 32'(of1), 32'(fl_m));
        check("count1", 32'(oc1), 32'(cnt_m[1]));
        if (reset && ov4 && !in_stall && !in_flush) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_empty: got transfer of %h expected no result pending", od4);
            end else begin
                check("sb_data", od4, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] d);
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit which, input string name);
        int n = 0;
        @(negedge clk);
        while (!(which ? ov1 : ov4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!(which ? ov1 : ov4)) begin
            miscompares++;
            $display("FAIL %s: out_valid got 0 after 20 cycles expected 1", name);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(ov4), 32'h0);
        check("rst_stall", 32'(os4), 32'h0);
        check("rst_data",  od4, 32'h0);
        check("rst_count", 32'(oc4), 32'h0);
        check("rst_flush", 32'(of1), 32'h0);
        @(posedge clk); #2;
        reset = 1'b1;

        // Basic result and latency
        send(32'h0000_0001);
        wait_valid(1'b0, "lat_d1");
        check("res_d1", od4, 32'h0000_000F);
        @(negedge clk);
        check("cnt_after_1", 32'(oc4), 32'h1);

        send(32'h8000_0000);
        wait_valid(1'b0, "lat_rot");
        check("res_rotwrap", od4, 32'h8000_0007);
        send(32'hFFFF_FFFF);
        wait_valid(1'b0, "lat_carry");
        check("res_carry", od4, 32'hFFFF_FFFC);
        @(negedge clk);
        check("cnt_after_3", 32'(oc4), 32'h3);

        // Downstream stall for 5 cycles
        @(posedge clk); #2;
        in_stall = 1'b1;
        send(32'h0000_0003);
        wait_valid(1'b0, "lat_stall");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(ov4), 32'h1);
            check("stall_data",  od4, 32'h0000_002D);
            check("stall_ostall", 32'(os4), 32'h1);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #2;
        in_stall = 1'b0;
        @(negedge clk);
        check("stall_last_valid", 32'(ov4), 32'h1);
        @(negedge clk);
        check("stall_xfer_valid", 32'(ov4), 32'h0);
        check("stall_xfer_count", 32'(oc4), 32'h4);

        // Flush during BUSY
        send(32'h1234_5678);
        in_flush = 1'b1;
        @(posedge clk); #2;
        in_flush = 1'b0;
        @(negedge clk);
        check("fb_valid", 32'(ov4), 32'h0);
        check("fb_stall", 32'(os4), 32'h0);
        check("fb_oflush", 32'(of4), 32'h1);
        check("fb_count", 32'(oc4), 32'h4);
        @(negedge clk);
        check("fb_oflush_end", 32'(of4), 32'h0);
        repeat (5) @(negedge clk);
        check("fb_no_result", 32'(ov4), 32'h0);

        // Flush in DONE with in_stall=0
        send(32'h0000_0001);
        repeat (3) @(posedge clk);
        #2;
        in_flush = 1'b1;
        @(negedge clk);
        check("fd_valid_before", 32'(ov4), 32'h1);
        @(posedge clk); #2;
        in_flush = 1'b0;
        @(negedge clk);
        check("fd_valid", 32'(ov4), 32'h0);
        check("fd_oflush", 32'(of4), 32'h1);
        check("fd_count", 32'(oc4), 32'h4);

        // ITER=1 back-to-back operands
        pulse_reset();
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_data  = 32'd5;
        @(posedge clk); #2;
        in_data  = 32'd7;
        @(negedge clk);
        check("b2b_valid5", 32'(ov1), 32'h1);
        check("b2b_data5", od1, 32'd5);
        @(posedge clk); #2;
        @(negedge clk);
        check("b2b_gap_valid", 32'(ov1), 32'h0);
        check("b2b_gap_stall", 32'(os1), 32'h0);
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid7", 32'(ov1), 32'h1);
        check("b2b_data7", od1, 32'd7);
        @(negedge clk);
        check("b2b_count", 32'(oc1), 32'h2);

        // Reset in the middle of BUSY
        repeat (4) @(posedge clk);
        send(32'hA5A5_A5A5);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("mr_valid", 32'(ov4), 32'h0);
        check("mr_stall", 32'(os4), 32'h0);
        check("mr_data",  od4, 32'h0);
        check("mr_count", 32'(oc4), 32'h0);
        check("mr_flush", 32'(of4), 32'h0);
        @(posedge clk); #2;
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("mr_no_output", 32'(ov4), 32'h0);
        end

        // Counter wrap from a preloaded 0xFFFF
        @(posedge clk); #2;
        force u_dut4.count_q = 16'hFFFF;
        preload = 1'b1;
        #1;
        release u_dut4.count_q;
        preload = 1'b0;
        @(negedge clk);
        check("wrap_pre", 32'(oc4), 32'hFFFF);
        send(32'h0000_0002);
        wait_valid(1'b0, "lat_wrap");
        @(negedge clk);
        check("wrap_post", 32'(oc4), 32'h0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            in_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: in_data = 32'hFFFF_FFFF;
                1: in_data = 32'h1 << $urandom_range(0, 31);
                default: in_data = $urandom;
            endcase
            in_flush = ($urandom_range(0, 15) == 0);
            in_stall = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
        in_flush = 1'b0;
        in_stall = 1'b0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation got no end expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
